// File: rtl/rx_port_rr_arbiter_pkg.sv
// Shared definitions for the four-port RX merge arbiter: where the source
// port code sits inside tuser, how a port number maps to its one-hot code,
// and the arbiter FSM encoding.
package nf10_rx_pkg;

  localparam int SRC_PORT_POS = 16;
  localparam int SRC_PORT_W   = 8;
  localparam int NUM_PORTS    = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_t;

  // Ports 0..3 map to 8'h01, 8'h04, 8'h10, 8'h40.
  function automatic logic [SRC_PORT_W-1:0] port_code(input logic [1:0] port);
    return 8'h01 << {port, 1'b0};
  endfunction

endpackage

// File: rtl/rx_port_rr_arbiter_if.sv
// AXI4-Stream bundle used for each MAC receive port and for the merged
// stream toward the DMA engine.
interface rx_port_rr_arbiter_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) ();

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (
    output tdata, tstrb, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tuser, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/rx_port_rr_arbiter_pick4.sv
// Combinational 4-way round-robin priority encoder: the search starts at
// ptr and wraps, and the first requesting port wins.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt,
  output logic       any
);

  // Walk from the farthest offset back to ptr so the nearest requester is written last.
  always_comb begin
    logic [1:0] idx;
    gnt = 2'd0;
    any = 1'b0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_port_rr_arbiter.sv
// Packet-granular round-robin merge of four MAC RX streams onto one DMA
// RX stream. A granted port is wired straight through until its tlast
// beat transfers; tuser[23:16] is overwritten with the one-hot source code.
module rx_port_rr_arbiter
  import nf10_rx_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH   = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  rx_port_rr_arbiter_if.slave     s_axis_0,
  rx_port_rr_arbiter_if.slave     s_axis_1,
  rx_port_rr_arbiter_if.slave     s_axis_2,
  rx_port_rr_arbiter_if.slave     s_axis_3,
  rx_port_rr_arbiter_if.master    m_axis,
  output logic [C_CNT_WIDTH-1:0]  pkt_cnt_0,
  output logic [C_CNT_WIDTH-1:0]  pkt_cnt_1,
  output logic [C_CNT_WIDTH-1:0]  pkt_cnt_2,
  output logic [C_CNT_WIDTH-1:0]  pkt_cnt_3
);

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  arb_state_t                state_q, state_d;
  logic [1:0]                grant_q, grant_d;
  logic [1:0]                rr_ptr_q, rr_ptr_d;
  logic [3:0]                req;
  logic [1:0]                pick_gnt;
  logic                      pick_any;
  logic                      pass;
  logic                      last_xfer;
  logic [C_DATA_WIDTH-1:0]   sel_tdata;
  logic [C_DATA_WIDTH/8-1:0] sel_tstrb;
  logic [C_TUSER_WIDTH-1:0]  sel_tuser;
  logic [C_TUSER_WIDTH-1:0]  tuser_out;
  logic                      sel_tvalid;
  logic                      sel_tlast;
  logic [C_CNT_WIDTH-1:0]    pkt_cnt_q [NUM_PORTS];

  assign req  = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
  assign pass = (state_q == ARB_PASS);

  rr_pick4 u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Select the granted port's beat; port 0 is the default route.
  always_comb begin
    sel_tdata  = s_axis_0.tdata;
    sel_tstrb  = s_axis_0.tstrb;
    sel_tuser  = s_axis_0.tuser;
    sel_tvalid = s_axis_0.tvalid;
    sel_tlast  = s_axis_0.tlast;
    case (grant_q)
      2'd1: begin
        sel_tdata  = s_axis_1.tdata;
        sel_tstrb  = s_axis_1.tstrb;
        sel_tuser  = s_axis_1.tuser;
        sel_tvalid = s_axis_1.tvalid;
        sel_tlast  = s_axis_1.tlast;
      end
      2'd2: begin
        sel_tdata  = s_axis_2.tdata;
        sel_tstrb  = s_axis_2.tstrb;
        sel_tuser  = s_axis_2.tuser;
        sel_tvalid = s_axis_2.tvalid;
        sel_tlast  = s_axis_2.tlast;
      end
      2'd3: begin
        sel_tdata  = s_axis_3.tdata;
        sel_tstrb  = s_axis_3.tstrb;
        sel_tuser  = s_axis_3.tuser;
        sel_tvalid = s_axis_3.tvalid;
        sel_tlast  = s_axis_3.tlast;
      end
      default: ;
    endcase
  end

  // Stamp the source port code into the tuser field, keeping every other bit.
  always_comb begin
    tuser_out = sel_tuser;
    tuser_out[SRC_PORT_POS +: SRC_PORT_W] = port_code(grant_q);
  end

  assign m_axis.tdata  = sel_tdata;
  assign m_axis.tstrb  = sel_tstrb;
  assign m_axis.tuser  = tuser_out;
  assign m_axis.tlast  = sel_tlast;
  assign m_axis.tvalid = pass & sel_tvalid;

  assign s_axis_0.tready = pass & (grant_q == 2'd0) & m_axis.tready;
  assign s_axis_1.tready = pass & (grant_q == 2'd1) & m_axis.tready;
  assign s_axis_2.tready = pass & (grant_q == 2'd2) & m_axis.tready;
  assign s_axis_3.tready = pass & (grant_q == 2'd3) & m_axis.tready;

  assign last_xfer = pass & sel_tvalid & m_axis.tready & sel_tlast;

  // Next-state logic: grant the round-robin winner in IDLE, release after the tlast transfer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          state_d = ARB_PASS;
        end
      end
      ARB_PASS: begin
        if (last_xfer) begin
          rr_ptr_d = grant_q + 2'd1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Per-port packet counters, bumped once per completed packet and wrapping silently.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else if (last_xfer) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + CNT_ONE;
    end
  end

  assign pkt_cnt_0 = pkt_cnt_q[0];
  assign pkt_cnt_1 = pkt_cnt_q[1];
  assign pkt_cnt_2 = pkt_cnt_q[2];
  assign pkt_cnt_3 = pkt_cnt_q[3];

endmodule

// File: tb/tb_rx_port_rr_arbiter.sv
// Scoreboard bench for rx_port_rr_arbiter: each scenario queues its
// hand-ordered expected beats, drivers push packets on the four ports, and
// a monitor pops and compares every beat the merged stream transfers.
module tb_rx_port_rr_arbiter;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;
  localparam int CW = 32;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_tready = 1'b1;
  logic [DW-1:0] tdata_drv  [4];
  logic [SW-1:0] tstrb_drv  [4];
  logic [UW-1:0] tuser_drv  [4];
  logic          tvalid_drv [4];
  logic          tlast_drv  [4];
  logic [3:0]    tready_obs;
  logic [CW-1:0] pkt_cnt    [4];
  logic [7:0]    code_tbl   [4] = '{8'h01, 8'h04, 8'h10, 8'h40};

  beat_t exp_q[$];
  beat_t mon_e;
  int    xfer_cyc[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  rx_port_rr_arbiter_if #(.DATA_W(DW), .USER_W(UW)) s_if [4] ();
  rx_port_rr_arbiter_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign s_if[g].tdata  = tdata_drv[g];
    assign s_if[g].tstrb  = tstrb_drv[g];
    assign s_if[g].tuser  = tuser_drv[g];
    assign s_if[g].tvalid = tvalid_drv[g];
    assign s_if[g].tlast  = tlast_drv[g];
    assign tready_obs[g]  = s_if[g].tready;
  end
  assign m_if.tready = m_tready;

  rx_port_rr_arbiter #(
    .C_DATA_WIDTH  (DW),
    .C_TUSER_WIDTH (UW),
    .C_CNT_WIDTH   (CW)
  ) dut (
    .axi_aclk   (clk),
    .axi_resetn (rst_n),
    .s_axis_0   (s_if[0]),
    .s_axis_1   (s_if[1]),
    .s_axis_2   (s_if[2]),
    .s_axis_3   (s_if[3]),
    .m_axis     (m_if),
    .pkt_cnt_0  (pkt_cnt[0]),
    .pkt_cnt_1  (pkt_cnt[1]),
    .pkt_cnt_2  (pkt_cnt[2]),
    .pkt_cnt_3  (pkt_cnt[3])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mk_data(input int p, input int pkt, input int b);
    logic [DW-1:0] d;
    d = '0;
    d[DW-1 -: 8] = 8'h5A;
    d[23:16] = 8'(p);
    d[15:8]  = 8'(pkt);
    d[7:0]   = 8'(b);
    return d;
  endfunction

  function automatic logic [SW-1:0] mk_strb(input logic last);
    return last ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [UW-1:0] mk_user(input int p, input int pkt);
    logic [UW-1:0] u;
    u = '0;
    u[127:64] = 64'hCAFE_F00D_1234_5678;
    u[31:24]  = 8'h99;
    u[23:16]  = 8'hEE;
    u[15:8]   = 8'(pkt);
    u[7:0]    = 8'(p);
    return u;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
  endtask

  task automatic push_exp(input int p, input int pkt, input int n);
    beat_t e;
    logic [UW-1:0] u;
    for (int b = 0; b < n; b++) begin
      u = mk_user(p, pkt);
      u[23:16] = code_tbl[p];
      e.d = mk_data(p, pkt, b);
      e.s = mk_strb(b == n - 1);
      e.u = u;
      e.l = (b == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input int p, input int pkt, input int b, input logic last);
    tdata_drv[p]  = mk_data(p, pkt, b);
    tstrb_drv[p]  = mk_strb(last);
    tuser_drv[p]  = mk_user(p, pkt);
    tlast_drv[p]  = last;
    tvalid_drv[p] = 1'b1;
  endtask

  // Sends an n-beat packet on port p; optionally drops tvalid for stall_len cycles before beat stall_at.
  task automatic applyStimulus(input int p, input int n, input int pkt, input int stall_at, input int stall_len);
    logic acc;
    int   waited;
    for (int b = 0; b < n; b++) begin
      if (b == stall_at && stall_len > 0) begin
        tvalid_drv[p] = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          checkOutput("stall_hold", {m_if.tvalid, tready_obs}, {1'b0, 4'b0001 << p});
          @(posedge clk);
          #1;
        end
      end
      drive_beat(p, pkt, b, b == n - 1);
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge clk);
        acc = tready_obs[p];
        @(posedge clk);
        #1;
        waited++;
        if (!acc && waited > 200) begin
          n_checks++;
          $display("[TB] FAIL accept_timeout: port %0d beat %0d got no tready, want tready within 200 cycles", p, b);
          break;
        end
      end
      if (!acc) break;
    end
    tvalid_drv[p] = 1'b0;
    tlast_drv[p]  = 1'b0;
  endtask

  // Monitor: every transferred beat on the merged stream must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_tready) begin
      xfer_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_beat: got data %0h, want no beat", m_if.tdata[23:0]);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_if.tdata === mon_e.d && m_if.tstrb === mon_e.s &&
            m_if.tuser === mon_e.u && m_if.tlast === mon_e.l) begin
          n_pass++;
        end else begin
          $display("[TB] FAIL beat: got data %0h strb %0h user %0h last %0b, want data %0h strb %0h user %0h last %0b",
                   m_if.tdata[23:0], m_if.tstrb, m_if.tuser, m_if.tlast,
                   mon_e.d[23:0], mon_e.s, mon_e.u, mon_e.l);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, want finish before 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    logic [5:0] bp_pat;
    bp_pat = 6'b111001;
    for (int i = 0; i < 4; i++) begin
      tdata_drv[i] = '0; tstrb_drv[i] = '0; tuser_drv[i] = '0;
      tvalid_drv[i] = 1'b0; tlast_drv[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_m_tvalid", m_if.tvalid, 0);
    checkOutput("rst_treadys", tready_obs, 0);
    for (int i = 0; i < 4; i++) checkOutput("rst_cnt", pkt_cnt[i], 0);

    // Single port: port 2, three beats
    push_exp(2, 1, 3);
    xfer_cyc.delete();
    start = cyc;
    applyStimulus(2, 3, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("single_beats", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      checkOutput("single_latency", xfer_cyc[0] - start, 1);
      checkOutput("single_span", xfer_cyc[2] - xfer_cyc[0], 2);
    end
    checkOutput("single_cnt2", pkt_cnt[2], 1);
    checkOutput("single_drain", exp_q.size(), 0);

    // All four request together right after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(0, 2, 2); push_exp(1, 3, 2); push_exp(2, 4, 2); push_exp(3, 5, 2);
    xfer_cyc.delete();
    start = cyc;
    fork
      applyStimulus(0, 2, 2, 0, 0);
      applyStimulus(1, 2, 3, 0, 0);
      applyStimulus(2, 2, 4, 0, 0);
      applyStimulus(3, 2, 5, 0, 0);
    join
    repeat (2) @(posedge clk);
    #1;
    checkOutput("all4_beats", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) begin
      checkOutput("all4_first", xfer_cyc[0] - start, 1);
      checkOutput("all4_bubble", xfer_cyc[2] - xfer_cyc[1], 2);
      checkOutput("all4_total", xfer_cyc[7] - start, 11);
    end
    for (int i = 0; i < 4; i++) checkOutput("all4_cnt", pkt_cnt[i], 1);
    checkOutput("all4_drain", exp_q.size(), 0);

    // Fairness: port 0 streams packets, port 3 cuts in after the current one
    push_exp(0, 10, 2); push_exp(3, 11, 2); push_exp(0, 12, 2); push_exp(0, 13, 2);
    xfer_cyc.delete();
    start = cyc;
    fork
      begin
        applyStimulus(0, 2, 10, 0, 0);
        applyStimulus(0, 2, 12, 0, 0);
        applyStimulus(0, 2, 13, 0, 0);
      end
      begin
        @(posedge clk);
        #1;
        applyStimulus(3, 2, 11, 0, 0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    if (xfer_cyc.size() >= 3) checkOutput("fair_p3_start", xfer_cyc[2] - start, 4);
    checkOutput("fair_cnt0", pkt_cnt[0], 4);
    checkOutput("fair_cnt3", pkt_cnt[3], 2);
    checkOutput("fair_drain", exp_q.size(), 0);

    // Backpressure on a 4-beat port 1 packet with port 2 waiting
    push_exp(1, 20, 4); push_exp(2, 21, 1);
    xfer_cyc.delete();
    start = cyc;
    fork
      applyStimulus(1, 4, 20, 0, 0);
      begin
        @(posedge clk);
        #1;
        applyStimulus(2, 1, 21, 0, 0);
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(posedge clk);
          #1;
          m_tready = bp_pat[c];
          @(negedge clk);
          checkOutput("bp_tready", tready_obs, bp_pat[c] ? 4'b0010 : 4'b0000);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    if (xfer_cyc.size() >= 2) checkOutput("bp_beat1_cycle", xfer_cyc[1] - start, 4);
    checkOutput("bp_cnt1", pkt_cnt[1], 2);
    checkOutput("bp_drain", exp_q.size(), 0);

    // Mid-packet stall on port 0 while port 1 waits
    push_exp(0, 30, 4); push_exp(1, 31, 2);
    fork
      applyStimulus(0, 4, 30, 2, 5);
      begin
        @(posedge clk);
        #1;
        applyStimulus(1, 2, 31, 0, 0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stall_cnt0", pkt_cnt[0], 5);
    checkOutput("stall_drain", exp_q.size(), 0);

    // Reset during beat 2 of a port 3 packet
    push_exp(3, 40, 1);
    exp_q[exp_q.size() - 1].s = mk_strb(1'b0);
    exp_q[exp_q.size() - 1].l = 1'b0;
    drive_beat(3, 40, 0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    drive_beat(3, 40, 1, 1'b0);
    checkOutput("rm_valid_before", m_if.tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rm_valid_async", m_if.tvalid, 0);
    checkOutput("rm_ready_async", tready_obs, 0);
    tvalid_drv[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) checkOutput("rm_cnt", pkt_cnt[i], 0);
    checkOutput("rm_drain", exp_q.size(), 0);

    // Arbitration restarts at port 0 after reset
    push_exp(0, 41, 1); push_exp(3, 42, 1);
    fork
      applyStimulus(3, 1, 42, 0, 0);
      applyStimulus(0, 1, 41, 0, 0);
    join
    repeat (3) @(posedge clk);
    #1;
    checkOutput("restart_cnt0", pkt_cnt[0], 1);
    checkOutput("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_port_rr_arbiter.md
# rx_port_rr_arbiter

Packet-granular round-robin arbiter that merges the four 10G MAC receive AXI4-Stream ports onto the single stream feeding the NIC DMA receive path. Each packet is tagged with a one-hot source-port code in `tuser`, so the DMA engine and host can tell which interface it came from. Packets are never interleaved. The block sits between the four `nf10_10g_interface` RX outputs and the DMA RX input in the `reference_nic` datapath.

## Interface
Parameters:
- `C_DATA_WIDTH`, 256: tdata width in bits; tstrb width is `C_DATA_WIDTH/8`.
- `C_TUSER_WIDTH`, 128: tuser width in bits; src_port field is `tuser[23:16]`.
- `C_CNT_WIDTH`, 32: width of each per-port packet counter.

Ports (clock and reset first):
- `axi_aclk`, in, 1: the only clock.
- `axi_resetn`, in, 1: asynchronous active-low reset.
- `s_axis_i_tdata`, in, C_DATA_WIDTH: port i data (i = 0..3, four separate ports).
- `s_axis_i_tstrb`, in, C_DATA_WIDTH/8: port i byte strobes.
- `s_axis_i_tuser`, in, C_TUSER_WIDTH: port i sideband.
- `s_axis_i_tvalid` / `s_axis_i_tlast`, in, 1 each: port i valid / end of packet.
- `s_axis_i_tready`, out, 1: port i ready.
- `m_axis_tdata` / `m_axis_tstrb` / `m_axis_tuser`, out, matching widths: merged stream.
- `m_axis_tvalid` / `m_axis_tlast`, out, 1 each: merged valid / end of packet.
- `m_axis_tready`, in, 1: DMA backpressure.
- `pkt_cnt_i`, out, C_CNT_WIDTH: packets forwarded from port i (i = 0..3).

## Operation
- FSM states: IDLE and PASS. Registers: `grant[1:0]`, `rr_ptr[1:0]`, the four counters.
- **IDLE**
  - Search order starts at `rr_ptr` and wraps: rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
  - The first port with `tvalid=1` becomes `grant`. The FSM moves to PASS.
  - If no port has `tvalid=1`, the FSM stays in IDLE.
  - All `s_axis_i_tready` are 0 and `m_axis_tvalid` is 0.
- **PASS**
  - The granted port connects combinationally to the master port:
    - `m_axis_tvalid = s_axis_g_tvalid`
    - `s_axis_g_tready = m_axis_tready`
    - data, strb and last pass through unchanged.
    - Non-granted ports have `tready=0`.
  - `m_axis_tuser` equals the granted tuser, except bits [23:16] are replaced by `8'h01 << (2*grant)`, giving 01, 04, 10, 40 for ports 0..3. All other tuser bits pass unchanged.
  - When a beat transfers with `tlast=1` (tvalid & tready & tlast):
    - `pkt_cnt_grant` increments.
    - `rr_ptr` becomes `grant+1` (mod 4).
    - The FSM returns to IDLE.
  - If the granted port drops tvalid mid-packet, the FSM stays in PASS and holds the grant indefinitely. There is no timeout.
- Counters wrap from all-ones to 0 silently.
- **Reset:** when `axi_resetn` is asserted:
  - The FSM goes to IDLE; grant=0, rr_ptr=0, all counters=0.
  - All `s_axis_i_tready` and `m_axis_tvalid` go to 0 immediately (asynchronous).
  - A packet in flight is truncated. Downstream must tolerate this; the arbiter does not complete it.

## Timing
- Arbitration latency: one cycle. A port asserting tvalid in IDLE sees its first beat accepted on the following cycle at the earliest, if `m_axis_tready=1`.
- There is one IDLE bubble cycle after every packet, including single-beat packets.
  - Peak throughput is N/(N+1) beats per cycle for N-beat packets.
- Within PASS the data path has zero latency; no output registers.
- Simultaneous requests resolve in a single cycle using `rr_ptr` order.
- A tvalid asserted in the same cycle that another port's tlast transfers is considered in the next IDLE cycle.
- Counters update on the cycle after the tlast transfer edge and are registered outputs.
- AXI4-Stream rules on the master port hold: once asserted, `m_axis_tvalid` and its data stay stable until `m_axis_tready`. This holds provided the slaves obey the same rule, because the path is a pass-through.

## Structure
- Shared package `nf10_rx_pkg` holds:
  - the src_port field position constants (`SRC_PORT_POS`=16, width 8);
  - the one-hot port code function;
  - the FSM state encoding.
- One sub-module is natural: `rr_pick4`, a combinational 4-way round-robin priority encoder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt[1:0], any.
- Everything else lives in the top.

## Test plan
- **Single port:** port 2 sends a 3-beat packet, `m_axis_tready=1`.
  - m_axis carries 3 beats starting 1 cycle after tvalid, with tuser[23:16]=8'h10.
  - `pkt_cnt_2`=1.
- **All four request simultaneously from reset:** each sends one 2-beat packet.
  - Output order is ports 0,1,2,3 with codes 01,04,10,40.
  - 1 idle cycle between packets; 12 cycles total.
- **Fairness:** port 0 sends back-to-back packets continuously while port 3 asserts one packet.
  - Port 3's packet is forwarded immediately after port 0's current packet completes.
  - Port 0's next packet follows.
- **Backpressure:** `m_axis_tready` toggles 1,0,0,1 during a 4-beat packet from port 1.
  - No beats are lost or duplicated.
  - `s_axis_1_tready` mirrors `m_axis_tready`.
  - Other ports see tready=0.
- **Mid-packet stall:** port 0 deasserts tvalid for 5 cycles mid-packet while port 1 is valid.
  - The grant stays on port 0; port 1 waits until port 0's tlast.
- **Reset mid-packet:** assert `axi_resetn`=0 during beat 2 of a port 3 packet.
  - `m_axis_tvalid` goes to 0 with no clock edge needed.
  - After release, counters are 0 and arbitration restarts at port 0.
